// File: rtl/oflow_score_calc_pkg.sv
// ============================================================================
// Module   : oflow_score_calc_pkg
// Purpose  : Shared types for the score-calc best-match stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package oflow_score_calc_pkg;

    localparam int SCORE_LEN = 16;
    localparam int ID_LEN    = 12;

    typedef enum logic [1:0] {
        IDLE_ST   = 2'd0,
        ACC_ST    = 2'd1,
        REPORT_ST = 2'd2
    } sm_type_t;

    typedef struct packed {
        logic [SCORE_LEN-1:0] score;
        logic [ID_LEN-1:0]    id;
    } cand_t;

endpackage

`default_nettype wire

// File: rtl/oflow_score_calc_best_match_if.sv
// ============================================================================
// Module   : oflow_score_calc_best_match_if
// Purpose  : Score strobes in, best-match result out. OFLOW_SECOND_BEST_EN
//            adds the second-best score signals.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface oflow_score_calc_best_match_if #(
    parameter int SCORE_LEN = oflow_score_calc_pkg::SCORE_LEN,
    parameter int ID_LEN    = oflow_score_calc_pkg::ID_LEN,
    parameter int CNT_LEN   = 8
);
    logic                 start_score_calc;
    logic                 done_score_calc;
    logic                 score_valid_0;
    logic [SCORE_LEN-1:0] score_0;
    logic [ID_LEN-1:0]    id_0;
    logic                 score_valid_1;
    logic [SCORE_LEN-1:0] score_1;
    logic [ID_LEN-1:0]    id_1;
    logic [SCORE_LEN-1:0] best_score;
    logic [ID_LEN-1:0]    best_id;
    logic                 best_found;
    logic [CNT_LEN-1:0]   cand_cnt;
    logic                 done_best_match;
`ifdef OFLOW_SECOND_BEST_EN
    logic [SCORE_LEN-1:0] second_score;
    logic                 second_valid;
`endif

    modport slave (
        input  start_score_calc, done_score_calc,
        input  score_valid_0, score_0, id_0,
        input  score_valid_1, score_1, id_1,
        output best_score, best_id, best_found, cand_cnt, done_best_match
`ifdef OFLOW_SECOND_BEST_EN
        , output second_score, second_valid
`endif
    );

    modport master (
        output start_score_calc, done_score_calc,
        output score_valid_0, score_0, id_0,
        output score_valid_1, score_1, id_1,
        input  best_score, best_id, best_found, cand_cnt, done_best_match
`ifdef OFLOW_SECOND_BEST_EN
        , input second_score, second_valid
`endif
    );

endinterface

`default_nettype wire

// File: rtl/oflow_score_calc_min_cmp.sv
// ============================================================================
// Module   : oflow_score_calc_min_cmp
// Purpose  : Pick the lower of two candidates, ties broken by lower ID.
//            OFLOW_SECOND_BEST_EN also exposes the losing score.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oflow_score_calc_min_cmp #(
    parameter int SCORE_LEN = 16,
    parameter int ID_LEN    = 12
) (
    input  wire logic                 i_a_vld,
    input  wire logic [SCORE_LEN-1:0] i_a_score,
    input  wire logic [ID_LEN-1:0]    i_a_id,
    input  wire logic                 i_b_vld,
    input  wire logic [SCORE_LEN-1:0] i_b_score,
    input  wire logic [ID_LEN-1:0]    i_b_id,
`ifdef OFLOW_SECOND_BEST_EN
    output logic                      o_lose_vld,
    output logic [SCORE_LEN-1:0]      o_lose_score,
`endif
    output logic [SCORE_LEN-1:0]      o_win_score,
    output logic [ID_LEN-1:0]         o_win_id
);

    logic w_a_wins;

    // A full (score, id) tie goes to A; both sides are identical then anyway.
    assign w_a_wins = i_a_vld && (!i_b_vld || (i_a_score < i_b_score) ||
                                  ((i_a_score == i_b_score) && (i_a_id <= i_b_id)));

    assign o_win_score = w_a_wins ? i_a_score : i_b_score;
    assign o_win_id    = w_a_wins ? i_a_id    : i_b_id;

`ifdef OFLOW_SECOND_BEST_EN
    assign o_lose_vld   = i_a_vld & i_b_vld;
    assign o_lose_score = w_a_wins ? i_b_score : i_a_score;
`endif

endmodule

`default_nettype wire

// File: rtl/oflow_score_calc_best_match.sv
// ============================================================================
// Module   : oflow_score_calc_best_match
// Purpose  : Track the minimum-score candidate over a score-calc pass and
//            publish it with a one-cycle pulse. OFLOW_SECOND_BEST_EN adds
//            second-best score tracking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oflow_score_calc_best_match #(
    parameter int                   SCORE_LEN       = 16,
    parameter int                   ID_LEN          = 12,
    parameter logic [SCORE_LEN-1:0] MATCH_THRESHOLD = 16'h0FFF,
    parameter int                   CNT_LEN         = 8
) (
    input wire logic                   clk,
    input wire logic                   reset_N,
    oflow_score_calc_best_match_if.slave bus
);
    import oflow_score_calc_pkg::*;

    sm_type_t             r_state;
    logic [SCORE_LEN-1:0] r_best_score;
    logic [ID_LEN-1:0]    r_best_id;
    logic                 r_best_found;
    logic [CNT_LEN-1:0]   r_cand_cnt;
    logic                 r_done;

    logic                 w_acc0, w_acc1, w_pick_vld;
    logic [SCORE_LEN-1:0] w_pick_score, w_new_score;
    logic [ID_LEN-1:0]    w_pick_id, w_new_id;
    logic [CNT_LEN:0]     w_cnt_sum;
    logic [CNT_LEN-1:0]   w_cnt_next;

    assign w_acc0     = bus.score_valid_0 && (bus.score_0 <= MATCH_THRESHOLD);
    assign w_acc1     = bus.score_valid_1 && (bus.score_1 <= MATCH_THRESHOLD);
    assign w_pick_vld = w_acc0 | w_acc1;

    assign w_cnt_sum  = {1'b0, r_cand_cnt} + {{CNT_LEN{1'b0}}, w_acc0}
                                           + {{CNT_LEN{1'b0}}, w_acc1};
    assign w_cnt_next = w_cnt_sum[CNT_LEN] ? {CNT_LEN{1'b1}} : w_cnt_sum[CNT_LEN-1:0];

`ifdef OFLOW_SECOND_BEST_EN
    logic                 r_second_valid;
    logic [SCORE_LEN-1:0] r_second_score;
    logic                 w_lose1_vld, w_lose2_vld, w_sec_vld;
    logic [SCORE_LEN-1:0] w_lose1_score, w_lose2_score, w_sec_score;
`endif

    oflow_score_calc_min_cmp #(.SCORE_LEN(SCORE_LEN), .ID_LEN(ID_LEN)) u_cmp_slots (
        .i_a_vld     (w_acc0),
        .i_a_score   (bus.score_0),
        .i_a_id      (bus.id_0),
        .i_b_vld     (w_acc1),
        .i_b_score   (bus.score_1),
        .i_b_id      (bus.id_1),
`ifdef OFLOW_SECOND_BEST_EN
        .o_lose_vld  (w_lose1_vld),
        .o_lose_score(w_lose1_score),
`endif
        .o_win_score (w_pick_score),
        .o_win_id    (w_pick_id)
    );

    // Running best only counts as a real candidate once something was accepted.
    oflow_score_calc_min_cmp #(.SCORE_LEN(SCORE_LEN), .ID_LEN(ID_LEN)) u_cmp_best (
        .i_a_vld     (w_pick_vld),
        .i_a_score   (w_pick_score),
        .i_a_id      (w_pick_id),
        .i_b_vld     (r_best_found),
        .i_b_score   (r_best_score),
        .i_b_id      (r_best_id),
`ifdef OFLOW_SECOND_BEST_EN
        .o_lose_vld  (w_lose2_vld),
        .o_lose_score(w_lose2_score),
`endif
        .o_win_score (w_new_score),
        .o_win_id    (w_new_id)
    );

`ifdef OFLOW_SECOND_BEST_EN
    // Second best = min of held second, slot-pair loser, displaced/losing best.
    always_comb begin
        w_sec_vld   = r_second_valid;
        w_sec_score = r_second_score;
        if (w_lose1_vld && (!w_sec_vld || (w_lose1_score < w_sec_score))) begin
            w_sec_vld   = 1'b1;
            w_sec_score = w_lose1_score;
        end
        if (w_lose2_vld && (!w_sec_vld || (w_lose2_score < w_sec_score))) begin
            w_sec_vld   = 1'b1;
            w_sec_score = w_lose2_score;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state        <= IDLE_ST;
            r_best_score   <= {SCORE_LEN{1'b1}};
            r_best_id      <= '0;
            r_best_found   <= 1'b0;
            r_cand_cnt     <= '0;
            r_done         <= 1'b0;
`ifdef OFLOW_SECOND_BEST_EN
            r_second_score <= {SCORE_LEN{1'b1}};
            r_second_valid <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE_ST, ACC_ST: begin
                    if (bus.start_score_calc) begin
                        r_state        <= ACC_ST;
                        r_best_score   <= {SCORE_LEN{1'b1}};
                        r_best_id      <= '0;
                        r_best_found   <= 1'b0;
                        r_cand_cnt     <= '0;
`ifdef OFLOW_SECOND_BEST_EN
                        r_second_score <= {SCORE_LEN{1'b1}};
                        r_second_valid <= 1'b0;
`endif
                    end else if (r_state == ACC_ST) begin
                        if (w_pick_vld) begin
                            r_best_score <= w_new_score;
                            r_best_id    <= w_new_id;
                            r_best_found <= 1'b1;
                        end
                        r_cand_cnt <= w_cnt_next;
`ifdef OFLOW_SECOND_BEST_EN
                        r_second_score <= w_sec_score;
                        r_second_valid <= w_sec_vld;
`endif
                        if (bus.done_score_calc) begin
                            r_state <= REPORT_ST;
                            r_done  <= 1'b1;
                        end
                    end
                end
                REPORT_ST: r_state <= IDLE_ST;
                default:   r_state <= IDLE_ST;
            endcase
        end
    end

    assign bus.best_score      = r_best_score;
    assign bus.best_id         = r_best_id;
    assign bus.best_found      = r_best_found;
    assign bus.cand_cnt        = r_cand_cnt;
    assign bus.done_best_match = r_done;
`ifdef OFLOW_SECOND_BEST_EN
    assign bus.second_score    = r_second_score;
    assign bus.second_valid    = r_second_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oflow_score_calc_best_match.sv
// ============================================================================
// Module   : tb_oflow_score_calc_best_match
// Purpose  : Directed and random checks of the best-match stage against a
//            queue-based model (second-best checks under OFLOW_SECOND_BEST_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oflow_score_calc_best_match;
    import oflow_score_calc_pkg::*;

    localparam int          SL     = 16;
    localparam int          IL     = 12;
    localparam int          CL     = 8;
    localparam logic [15:0] TH     = 16'h0FFF;
    localparam int          CNTMAX = 255;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    always #5 clk = ~clk;

    oflow_score_calc_best_match_if #(.SCORE_LEN(SL), .ID_LEN(IL), .CNT_LEN(CL)) bus ();

    oflow_score_calc_best_match #(
        .SCORE_LEN(SL), .ID_LEN(IL), .MATCH_THRESHOLD(TH), .CNT_LEN(CL)
    ) dut (
        .clk    (clk),
        .reset_N(reset_N),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: accepted candidates of the current pass, plus pass phase.
    cand_t q[$];
    int    phase = 0;   // 0 idle, 1 accumulating, 2 reporting

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        cand_t b;
        int    n;
        b.score = '1;
        b.id    = '0;
        foreach (q[k])
            if (q[k].score < b.score || (q[k].score == b.score && q[k].id < b.id)) b = q[k];
        n = q.size();
        chk({tag, "/done"},  {31'd0, bus.done_best_match}, {31'd0, phase == 2});
        chk({tag, "/score"}, {16'd0, bus.best_score},      {16'd0, b.score});
        chk({tag, "/id"},    {20'd0, bus.best_id},         {20'd0, b.id});
        chk({tag, "/found"}, {31'd0, bus.best_found},      {31'd0, n > 0});
        chk({tag, "/cnt"},   {24'd0, bus.cand_cnt},        (n > CNTMAX) ? CNTMAX : n);
`ifdef OFLOW_SECOND_BEST_EN
        begin
            logic [15:0] sc[$];
            foreach (q[k]) sc.push_back(q[k].score);
            sc.sort();
            chk({tag, "/sec_v"}, {31'd0, bus.second_valid}, {31'd0, n >= 2});
            chk({tag, "/sec_s"}, {16'd0, bus.second_score}, {16'd0, (n >= 2) ? sc[1] : 16'hFFFF});
        end
`endif
    endtask

    task automatic cyc(input string tag, input bit st, input bit dn,
                       input bit v0, input logic [15:0] s0, input logic [11:0] i0,
                       input bit v1, input logic [15:0] s1, input logic [11:0] i1);
        bus.start_score_calc = st;
        bus.done_score_calc  = dn;
        bus.score_valid_0 = v0; bus.score_0 = s0; bus.id_0 = i0;
        bus.score_valid_1 = v1; bus.score_1 = s1; bus.id_1 = i1;
        @(posedge clk);
        case (phase)
            0: if (st) begin q.delete(); phase = 1; end
            1: if (st) q.delete();
               else begin
                   if (v0 && s0 <= TH) q.push_back('{score: s0, id: i0});
                   if (v1 && s1 <= TH) q.push_back('{score: s1, id: i1});
                   if (dn) phase = 2;
               end
            default: phase = 0;
        endcase
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 16'h0, 12'h0, 0, 16'h0, 12'h0);
    endtask

    function automatic logic [15:0] rnd_score();
        case ($urandom_range(0, 3))
            0:       return ($urandom_range(0, 1) != 0) ? 16'h0FFF : 16'h1000;
            1:       return 16'($urandom_range(0, 7));
            default: return 16'($urandom_range(0, 16'h1400));
        endcase
    endfunction

    task automatic rcyc(input string tag, input bit st, input bit dn);
        cyc(tag, st, dn, $urandom_range(0, 1) != 0, rnd_score(), 12'($urandom_range(0, 7)),
                         $urandom_range(0, 1) != 0, rnd_score(), 12'($urandom_range(0, 7)));
    endtask

    initial begin
        bus.start_score_calc = 0; bus.done_score_calc = 0;
        bus.score_valid_0 = 0; bus.score_0 = 0; bus.id_0 = 0;
        bus.score_valid_1 = 0; bus.score_1 = 0; bus.id_1 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset_N = 1'b1;
        idle("post_reset");

        // Same-cycle pair: slot 1 wins on score
        cyc("t1_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1_pair",  0, 0, 1, 16'h0200, 12'd5, 1, 16'h0100, 12'd9);
        cyc("t1_done",  0, 1, 0, 0, 0, 0, 0, 0);
        chk("t1_pulse", {31'd0, bus.done_best_match}, 32'd1);
        chk("t1_id",    {20'd0, bus.best_id}, 32'd9);
        idle("t1_after");

        // Equal scores across cycles: lower ID wins
        cyc("t2_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t2_a",     0, 0, 1, 16'h0300, 12'd7, 0, 0, 0);
        cyc("t2_b",     0, 0, 0, 0, 0, 1, 16'h0300, 12'd3);
        cyc("t2_done",  0, 1, 0, 0, 0, 0, 0, 0);
        chk("t2_id", {20'd0, bus.best_id}, 32'd3);
        idle("t2_after");

        // Threshold edges
        cyc("t3_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_pair",  0, 0, 1, 16'h0FFF, 12'd1, 1, 16'h1000, 12'd2);
        cyc("t3_done",  0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_cnt", {24'd0, bus.cand_cnt}, 32'd1);
        idle("t3_after");
        cyc("t3n_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3n_pair",  0, 0, 1, 16'h1000, 12'd1, 1, 16'h1000, 12'd2);
        cyc("t3n_done",  0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3n_found", {31'd0, bus.best_found}, 32'd0);
        chk("t3n_score", {16'd0, bus.best_score}, 32'hFFFF);
        idle("t3n_after");

        // Score folded in on the done cycle
        cyc("t4_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4_done",  0, 1, 1, 16'h0010, 12'd4, 0, 0, 0);
        chk("t4_id", {20'd0, bus.best_id}, 32'd4);
        // start during REPORT is ignored
        cyc("t4_rep_start", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("t4_after");

        // Abort mid-pass
        cyc("t5_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5_a",     0, 0, 1, 16'h0005, 12'd8, 0, 0, 0);
        cyc("t5_abort", 1, 0, 1, 16'h0001, 12'd6, 0, 0, 0);
        cyc("t5_b",     0, 0, 0, 0, 0, 1, 16'h0050, 12'd2);
        cyc("t5_done",  0, 1, 0, 0, 0, 0, 0, 0);
        chk("t5_id", {20'd0, bus.best_id}, 32'd2);
        idle("t5_after");

        // done alone in idle: no pulse; start+done in idle: start wins
        cyc("idle_done", 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("idle_sd",   1, 1, 1, 16'h0002, 12'd1, 0, 0, 0);
        cyc("sd_a",      0, 0, 1, 16'h0003, 12'd1, 0, 0, 0);

        // Reset mid-pass, asserted away from the clock edge
        #2 reset_N = 1'b0;
        #1;
        q.delete(); phase = 0;
        check_all("rst_async");
        @(posedge clk); #1;
        check_all("rst_hold");
        reset_N = 1'b1;
        idle("rst_rel");

        // Saturation of the candidate counter
        cyc("sat_start", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 130; k++) cyc("sat", 0, 0, 1, 16'h0040, 12'd5, 1, 16'h0041, 12'd6);
        cyc("sat_done", 0, 1, 0, 0, 0, 0, 0, 0);
        chk("sat_cnt", {24'd0, bus.cand_cnt}, 32'd255);
        idle("sat_after");

        // Second-best ordering
        cyc("t6_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t6_a",     0, 0, 1, 16'h0040, 12'd1, 0, 0, 0);
        cyc("t6_b",     0, 0, 1, 16'h0020, 12'd2, 0, 0, 0);
        cyc("t6_c",     0, 0, 0, 0, 0, 1, 16'h0030, 12'd3);
        cyc("t6_done",  0, 1, 0, 0, 0, 0, 0, 0);
        chk("t6_best", {16'd0, bus.best_score}, 32'h0020);
`ifdef OFLOW_SECOND_BEST_EN
        chk("t6_second", {16'd0, bus.second_score}, 32'h0030);
`endif
        idle("t6_after");

        // Random passes with occasional aborts and stray controls
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 16);
            if ($urandom_range(0, 3) == 0) rcyc("r_idle_done", 0, 1);
            rcyc("r_start", 1, $urandom_range(0, 1) != 0);
            for (int c = 0; c < len; c++) rcyc("r_acc", $urandom_range(0, 19) == 0, 0);
            rcyc("r_done", 0, 1);
            rcyc("r_report", $urandom_range(0, 1) != 0, 0);
            if (phase != 0) idle("r_settle");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
